jt900h_bankrf: RTL and testbench
================================

// Module: jt900h_bankrf
// PURPOSE
//  Parametrised banked register file for the JT900H core: NBANK banks of four 32-bit accumulators plus four global 32-bit pointers.
//  Provides NRD registered read ports, one write port with byte/word/long lanes, write-to-read bypass and a bank pointer (RFP) with load/inc/dec.
//  Sits between the ucode control unit and the ALU operand latches; replaces the fixed 4-bank, single-mux storage in the register block.
// PARAMETERS
//  NBANK  4   number of accumulator banks; power of two, >=2
//  NRD    2   number of independent read ports
//  BW     $clog2(NBANK)  bank index width (derived, not overridden)
//  AW     BW+6           register address width (derived)
// PORTS
//  clk       in   1        clock
//  rst       in   1        reset, asynchronous, active-high
//  cen       in   1        clock enable; all state advances only when high
//  rd_req    in   NRD      read request per port
//  rd_addr   in   NRD*AW   read address per port, format below
//  rd_size   in   NRD*2    per port: 0 byte, 1 word, 2/3 long
//  rd_sex    in   NRD      per port: 1 sign-extend, 0 zero-extend
//  rd_data   out  NRD*32   registered read data
//  rd_valid  out  NRD      high one cen cycle after the matching rd_req
//  wr_en     in   1        write strobe
//  wr_addr   in   AW       write address
//  wr_size   in   2        0 byte, 1 word, 2/3 long
//  wr_data   in   32       write data, right-aligned
//  rfp_op    in   2        0 hold, 1 load rfp_din, 2 increment, 3 decrement
//  rfp_din   in   BW       value for rfp load
//  rfp       out  BW       current bank pointer
// BEHAVIOUR
//  Address = {ptr, cur, bank[BW-1:0], idx[1:0], lane[1:0]}.
//   ptr=1: pointer[idx]; cur and bank ignored. ptr=0, cur=1: accumulator[rfp][idx]. ptr=0, cur=0: accumulator[bank][idx].
//   lane: byte lane 0..3 for byte; word uses lane[1] and ignores lane[0]; long ignores lane.
//  Reset: all accumulators, pointers, rfp, rd_data and rd_valid = 0.
//  cen low: no register, rfp, rd_data or rd_valid changes, including with wr_en/rd_req high.
//  Read, latency 1 cen cycle: on a cen edge with rd_req[i] high, rd_data[i] <= selected lane shifted to bit 0, extended to 32 bits per rd_sex[i].
//   rd_valid[i] <= rd_req[i] on every cen edge. With rd_req[i] low, rd_data[i] holds.
//  Write: on a cen edge with wr_en high, only the addressed lane(s) update; other bits of the 32-bit register are kept.
//  Bypass: a read and write to the same 32-bit register on the same cen edge return the post-write merged value,
//   including partial overlap (e.g. byte write into a long read).
//  cur-relative addressing in reads and writes always uses rfp before any same-cycle rfp_op update.
//  rfp: inc wraps NBANK-1 -> 0; dec wraps 0 -> NBANK-1; load takes rfp_din. Updates on cen edge, visible next cycle.
//  Concurrent ports: all NRD reads plus the write complete in one cycle, no stalls, no ordering between read ports.
//  Reset mid-operation clears all state immediately and drops any pending rd_valid.
// TESTING
//  1 After reset, read ports 0/1 on acc[0][0] long, then ptr[3] long -> rd_data 0, rd_valid 1 next cycle only.
//  2 Write long 0x11223344 to acc[2][1], read byte lane 3 sex=0 -> 0x00000011; word lane 2 -> 0x00001122.
//  3 Write byte 0x80 to lane 0 of ptr[1] (0xAABBCCDD); read byte sex=1 same cycle -> 0xFFFFFF80; long next cycle -> 0xAABBCC80.
//  4 rfp=NBANK-1: inc -> 0; dec from 0 -> NBANK-1. Write with cur=1 in the inc cycle lands in bank NBANK-1.
//  5 Hold cen=0 for 3 cycles with wr_en and rd_req high -> no state change; cen=1 -> write and read both complete.
//  6 Assert rst mid-burst of back-to-back reads -> rd_valid 0 and rd_data 0 at once; first post-reset read returns 0.

Source files
------------

// File: rtl/jt900h_bankrf_if.sv
// Bus bundle between the ucode control unit (master) and the banked
// register file (slave): NRD read ports, one write port and the bank pointer.
interface jt900h_bankrf_if #(
    parameter int NBANK = 4,
    parameter int NRD   = 2
);
    localparam int BW = $clog2(NBANK);
    localparam int AW = BW + 6;

    logic [NRD-1:0]      rd_req;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*2-1:0]    rd_size;
    logic [NRD-1:0]      rd_sex;
    logic [NRD*32-1:0]   rd_data;
    logic [NRD-1:0]      rd_valid;

    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [1:0]          wr_size;
    logic [31:0]         wr_data;

    logic [1:0]          rfp_op;
    logic [BW-1:0]       rfp_din;
    logic [BW-1:0]       rfp;

    modport master (
        output rd_req, rd_addr, rd_size, rd_sex,
        output wr_en, wr_addr, wr_size, wr_data,
        output rfp_op, rfp_din,
        input  rd_data, rd_valid, rfp
    );

    modport slave (
        input  rd_req, rd_addr, rd_size, rd_sex,
        input  wr_en, wr_addr, wr_size, wr_data,
        input  rfp_op, rfp_din,
        output rd_data, rd_valid, rfp
    );
endinterface

// File: rtl/jt900h_bankrf.sv
// Banked register file: NBANK banks of four 32-bit accumulators plus four
// global pointers, NRD registered read ports with lane extraction and
// sign/zero extension, one lane-masked write port with write-to-read bypass,
// and the RFP bank pointer.
module jt900h_bankrf #(
    parameter int NBANK = 4,
    parameter int NRD   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    jt900h_bankrf_if.slave   bus
);
    localparam int BW   = $clog2(NBANK);
    localparam int AW   = BW + 6;
    localparam int NREG = NBANK * 4 + 4;     // accumulators first, pointers last
    localparam int RW   = $clog2(NREG);

    typedef enum logic [1:0] {
        RFP_HOLD = 2'd0,
        RFP_LOAD = 2'd1,
        RFP_INC  = 2'd2,
        RFP_DEC  = 2'd3
    } rfp_op_e;

    logic [31:0]       regs [NREG];
    logic [BW-1:0]     rfp_q;
    logic [NRD*32-1:0] rd_data_q;
    logic [NRD-1:0]    rd_valid_q;

    logic [RW-1:0]     wr_sel;
    logic [31:0]       wr_merged;
    logic [RW-1:0]     rd_sel  [NRD];
    logic [31:0]       rd_raw  [NRD];
    logic [31:0]       rd_next [NRD];

    // Map an address onto the flat register index; cur uses the pre-update rfp.
    function automatic logic [RW-1:0] reg_sel(input logic [AW-1:0] addr,
                                              input logic [BW-1:0] cur_bank);
        logic [BW-1:0] b;
        b = addr[AW-2] ? cur_bank : addr[AW-3:4];
        if (addr[AW-1])
            return RW'(NBANK * 4) + RW'(addr[3:2]);
        return RW'({b, addr[3:2]});
    endfunction

    // Overlay the right-aligned write data onto the addressed lane(s).
    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] din,
                                          input logic [1:0]  size,
                                          input logic [1:0]  lane);
        logic [31:0] r;
        r = old;
        case (size)
            2'd0:    r[lane*8 +: 8]       = din[7:0];
            2'd1:    r[lane[1]*16 +: 16]  = din[15:0];
            default: r                    = din;
        endcase
        return r;
    endfunction

    // Shift the addressed lane to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] v,
                                            input logic [1:0]  size,
                                            input logic [1:0]  lane,
                                            input logic        sex);
        logic [7:0]  b;
        logic [15:0] w;
        b = v[lane*8 +: 8];
        w = v[lane[1]*16 +: 16];
        case (size)
            2'd0:    return {{24{sex & b[7]}}, b};
            2'd1:    return {{16{sex & w[15]}}, w};
            default: return v;
        endcase
    endfunction

    // Write target and its merged value; reads share this for the bypass.
    always_comb begin
        wr_sel    = reg_sel(bus.wr_addr, rfp_q);
        wr_merged = merge(regs[wr_sel], bus.wr_data, bus.wr_size, bus.wr_addr[1:0]);
    end

    // Per-port register select, same-edge write bypass and lane extraction.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        for (int i = 0; i < NRD; i++) begin
            rd_sel[i]  = '0;
            rd_raw[i]  = '0;
            rd_next[i] = '0;
        end
        for (int i = 0; i < NRD; i++) begin
            rd_sel[i]  = reg_sel(bus.rd_addr[i*AW +: AW], rfp_q);
            rd_raw[i]  = (bus.wr_en && rd_sel[i] == wr_sel) ? wr_merged : regs[rd_sel[i]];
            rd_next[i] = extract(rd_raw[i], bus.rd_size[i*2 +: 2],
                                 bus.rd_addr[i*AW +: 2], bus.rd_sex[i]);
        end
    end

    // Register storage: lane-masked write on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset explicitly; software relies on zeroed accumulators and pointers.
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else if (cen && bus.wr_en) begin
            // NOTE: non-blocking so all same-edge readers see the pre-edge contents.
            regs[wr_sel] <= wr_merged;
        end
    end

    // Bank pointer: load / wrap-around increment / wrap-around decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rfp_q <= '0;
        end else if (cen) begin
            case (rfp_op_e'(bus.rfp_op))
                RFP_LOAD: rfp_q <= bus.rfp_din;
                RFP_INC:  rfp_q <= rfp_q + 1'b1;
                RFP_DEC:  rfp_q <= rfp_q - 1'b1;
                default:  rfp_q <= rfp_q;
            endcase
        end
    end

    // Read ports: capture data on request, valid follows request by one cen cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
        end else if (cen) begin
            rd_valid_q <= bus.rd_req;
            for (int i = 0; i < NRD; i++)
                if (bus.rd_req[i])
                    rd_data_q[i*32 +: 32] <= rd_next[i];
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rfp      = rfp_q;
endmodule

// File: tb/tb_jt900h_bankrf.sv
// Testbench for jt900h_bankrf: directed vector table, hand-written corner
// sequences and randomized traffic against an array-based reference model.
module tb_jt900h_bankrf;
    localparam int NBANK = 4;
    localparam int NRD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;

    int total = 0;
    int bad   = 0;

    jt900h_bankrf_if #(.NBANK(NBANK), .NRD(NRD)) bus ();

    jt900h_bankrf #(.NBANK(NBANK), .NRD(NRD)) dut (
        .clk (clk),
        .rst (rst),
        .cen (cen),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] acc_m [NBANK][4];
    logic [31:0] ptr_m [4];
    logic [1:0]  rfp_m;
    logic [31:0] exp_data [NRD];
    logic [1:0]  exp_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NBANK; b++)
            for (int i = 0; i < 4; i++)
                acc_m[b][i] = '0;
        for (int i = 0; i < 4; i++) ptr_m[i] = '0;
        rfp_m = '0;
        for (int i = 0; i < NRD; i++) exp_data[i] = '0;
        exp_valid = '0;
    endtask

    function automatic logic [31:0] m_fetch(input logic [7:0] a, input logic [1:0] cur);
        if (a[7]) return ptr_m[a[3:2]];
        if (a[6]) return acc_m[cur][a[3:2]];
        return acc_m[a[5:4]][a[3:2]];
    endfunction

    // Shift amount and field mask for a size/lane pair.
    function automatic void lane_info(input logic [1:0] size, input logic [1:0] lane,
                                      output int sh, output logic [31:0] m);
        if (size == 2'd0) begin
            sh = int'(lane) * 8;  m = 32'h0000_00FF;
        end else if (size == 2'd1) begin
            sh = (lane >= 2'd2) ? 16 : 0;  m = 32'h0000_FFFF;
        end else begin
            sh = 0;  m = 32'hFFFF_FFFF;
        end
    endfunction

    function automatic logic [31:0] m_extract(input logic [31:0] v, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sex);
        int sh;
        logic [31:0] m, r;
        lane_info(size, lane, sh, m);
        r = (v >> sh) & m;
        if (sex && (r & ((m >> 1) + 32'd1)) != 0) r = r | ~m;
        return r;
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [1:0] size,
                           input logic [31:0] data, input logic [1:0] cur);
        int sh;
        logic [31:0] m, nv;
        lane_info(size, a[1:0], sh, m);
        nv = (m_fetch(a, cur) & ~(m << sh)) | ((data & m) << sh);
        if (a[7])      ptr_m[a[3:2]] = nv;
        else if (a[6]) acc_m[cur][a[3:2]] = nv;
        else           acc_m[a[5:4]][a[3:2]] = nv;
    endtask

    // Apply the spec rules for the coming edge, then advance one clock.
    task automatic cycle();
        logic [1:0] cur;
        cur = rfp_m;
        if (cen) begin
            if (bus.wr_en) m_write(bus.wr_addr, bus.wr_size, bus.wr_data, cur);
            for (int i = 0; i < NRD; i++)
                if (bus.rd_req[i])
                    exp_data[i] = m_extract(m_fetch(bus.rd_addr[i*8 +: 8], cur),
                                            bus.rd_size[i*2 +: 2], bus.rd_addr[i*8 +: 2],
                                            bus.rd_sex[i]);
            exp_valid = bus.rd_req;
            case (bus.rfp_op)
                2'd1: rfp_m = bus.rfp_din;
                2'd2: rfp_m = rfp_m + 2'd1;
                2'd3: rfp_m = rfp_m - 2'd1;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cen = 1'b1;
        bus.rd_req = '0;  bus.rd_addr = '0;  bus.rd_size = '0;  bus.rd_sex = '0;
        bus.wr_en = 1'b0; bus.wr_addr = '0;  bus.wr_size = '0;  bus.wr_data = '0;
        bus.rfp_op = 2'd0; bus.rfp_din = '0;
    endtask

    function automatic logic [7:0] a_acc(input int bank, input int idx, input int lane);
        return {2'b00, 2'(bank), 2'(idx), 2'(lane)};
    endfunction
    function automatic logic [7:0] a_cur(input int idx, input int lane);
        return {2'b01, 2'b00, 2'(idx), 2'(lane)};
    endfunction
    function automatic logic [7:0] a_ptr(input int idx, input int lane);
        return {2'b10, 2'b00, 2'(idx), 2'(lane)};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        wr_en;
        logic [7:0]  wr_addr;
        logic [1:0]  wr_size;
        logic [31:0] wr_data;
        logic        rd_req;
        logic [7:0]  rd_addr;
        logic [1:0]  rd_size;
        logic        rd_sex;
        logic [31:0] exp_data;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0] wa;

        vecs[0] = '{"wr_long_acc21",  1, a_acc(2,1,0), 2'd2, 32'h1122_3344, 0, 8'h00,        2'd0, 0, 32'h0000_0000, 0};
        vecs[1] = '{"rd_byte3_zx",    0, 8'h00,        2'd0, 32'h0,         1, a_acc(2,1,3), 2'd0, 0, 32'h0000_0011, 1};
        vecs[2] = '{"rd_word_hi_zx",  0, 8'h00,        2'd0, 32'h0,         1, a_acc(2,1,2), 2'd1, 0, 32'h0000_1122, 1};
        vecs[3] = '{"wr_long_ptr1",   1, a_ptr(1,0),   2'd2, 32'hAABB_CCDD, 0, 8'h00,        2'd0, 0, 32'h0000_1122, 0};
        vecs[4] = '{"bypass_byte_sx", 1, a_ptr(1,0),   2'd0, 32'h1234_5680, 1, a_ptr(1,0),   2'd0, 1, 32'hFFFF_FF80, 1};
        vecs[5] = '{"ptr_ign_bank",   0, 8'h00,        2'd0, 32'h0,         1, 8'hF4,        2'd3, 0, 32'hAABB_CC80, 1};
        vecs[6] = '{"bypass_word_lg", 1, a_acc(2,1,2), 2'd1, 32'h0000_BEEF, 1, a_acc(2,1,0), 2'd2, 0, 32'hBEEF_3344, 1};
        vecs[7] = '{"rd_word_lo_sx",  0, 8'h00,        2'd0, 32'h0,         1, a_acc(2,1,0), 2'd1, 1, 32'h0000_3344, 1};
        vecs[8] = '{"rd_word_l3_sx",  0, 8'h00,        2'd0, 32'h0,         1, a_acc(2,1,3), 2'd1, 1, 32'hFFFF_BEEF, 1};
        vecs[9] = '{"rd_byte2_sx",    0, 8'h00,        2'd0, 32'h0,         1, a_acc(2,1,2), 2'd0, 1, 32'hFFFF_FFEF, 1};

        idle_inputs();
        cen = 1'b0;
        model_reset();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(bus.rd_valid), 32'h0);
        check("reset_data0", bus.rd_data[31:0], 32'h0);
        check("reset_rfp",   32'(bus.rfp), 32'h0);
        rst = 1'b0;
        idle_inputs();

        // ---- first reads after reset ----
        bus.rd_req = 2'b11;
        bus.rd_addr[7:0]  = a_acc(0,0,0);  bus.rd_size[1:0] = 2'd2;
        bus.rd_addr[15:8] = a_ptr(3,0);    bus.rd_size[3:2] = 2'd2;
        cycle();
        check("post_rst_valid", 32'(bus.rd_valid), 32'h3);
        check("post_rst_data0", bus.rd_data[31:0],  32'h0);
        check("post_rst_data1", bus.rd_data[63:32], 32'h0);
        idle_inputs();
        cycle();
        check("valid_one_cycle", 32'(bus.rd_valid), 32'h0);

        // ---- vector table on port 0 ----
        for (int v = 0; v < 10; v++) begin
            idle_inputs();
            bus.wr_en   = vecs[v].wr_en;   bus.wr_addr = vecs[v].wr_addr;
            bus.wr_size = vecs[v].wr_size; bus.wr_data = vecs[v].wr_data;
            bus.rd_req[0]     = vecs[v].rd_req;
            bus.rd_addr[7:0]  = vecs[v].rd_addr;
            bus.rd_size[1:0]  = vecs[v].rd_size;
            bus.rd_sex[0]     = vecs[v].rd_sex;
            cycle();
            check({vecs[v].name, "_data"},  bus.rd_data[31:0], vecs[v].exp_data);
            check({vecs[v].name, "_valid"}, 32'(bus.rd_valid[0]), 32'(vecs[v].exp_valid));
        end

        // ---- rfp wrap and cur-relative write in the inc cycle ----
        idle_inputs();
        bus.rfp_op = 2'd1;  bus.rfp_din = 2'd3;
        cycle();
        check("rfp_load", 32'(bus.rfp), 32'h3);
        idle_inputs();
        bus.rfp_op = 2'd2;
        bus.wr_en = 1'b1;  bus.wr_addr = a_cur(0,0);  bus.wr_size = 2'd2;  bus.wr_data = 32'hCAFE_0003;
        cycle();
        check("rfp_inc_wrap", 32'(bus.rfp), 32'h0);
        idle_inputs();
        bus.rfp_op = 2'd3;
        bus.rd_req = 2'b11;
        bus.rd_addr[7:0]  = a_acc(3,0,0);  bus.rd_size[1:0] = 2'd2;
        bus.rd_addr[15:8] = a_acc(0,0,0);  bus.rd_size[3:2] = 2'd2;
        cycle();
        check("rfp_dec_wrap",   32'(bus.rfp), 32'h3);
        check("cur_wr_old_rfp", bus.rd_data[31:0],  32'hCAFE_0003);
        check("cur_wr_not_b0",  bus.rd_data[63:32], 32'h0);

        // ---- clock enable held low ----
        idle_inputs();
        cen = 1'b0;
        bus.rfp_op = 2'd2;
        bus.wr_en = 1'b1;  bus.wr_addr = a_acc(1,2,0);  bus.wr_size = 2'd2;  bus.wr_data = 32'h5A5A_5A5A;
        bus.rd_req = 2'b01;  bus.rd_addr[7:0] = a_acc(1,2,0);  bus.rd_size[1:0] = 2'd2;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("cen0_data",  bus.rd_data[31:0], 32'hCAFE_0003);
            check("cen0_valid", 32'(bus.rd_valid), 32'h3);
            check("cen0_rfp",   32'(bus.rfp), 32'h3);
        end
        cen = 1'b1;
        cycle();
        check("cen1_data",  bus.rd_data[31:0], 32'h5A5A_5A5A);
        check("cen1_valid", 32'(bus.rd_valid), 32'h1);
        check("cen1_rfp",   32'(bus.rfp), 32'h0);

        // ---- reset in the middle of back-to-back reads ----
        idle_inputs();
        bus.rd_req = 2'b11;
        bus.rd_addr[7:0]  = a_ptr(1,0);    bus.rd_size[1:0] = 2'd2;
        bus.rd_addr[15:8] = a_acc(1,2,0);  bus.rd_size[3:2] = 2'd2;
        cycle();
        check("burst_data0", bus.rd_data[31:0],  32'hAABB_CC80);
        check("burst_data1", bus.rd_data[63:32], 32'h5A5A_5A5A);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.rd_valid),    32'h0);
        check("midrst_data0", bus.rd_data[31:0],    32'h0);
        check("midrst_data1", bus.rd_data[63:32],   32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        bus.rd_req = 2'b01;  bus.rd_addr[7:0] = a_ptr(1,0);  bus.rd_size[1:0] = 2'd2;
        cycle();
        check("after_rst_read", bus.rd_data[31:0], 32'h0);
        check("after_rst_vld",  32'(bus.rd_valid), 32'h1);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            cen         = ($urandom_range(0, 7) != 0);
            bus.wr_en   = 1'($urandom_range(0, 1));
            wa          = 8'($urandom);
            bus.wr_addr = wa;
            bus.wr_size = 2'($urandom);
            bus.wr_data = $urandom;
            bus.rd_req  = 2'($urandom);
            bus.rd_addr = 16'($urandom);
            if ($urandom_range(0, 2) == 0) bus.rd_addr[7:0] = {wa[7:2], 2'($urandom)};
            bus.rd_size = 4'($urandom);
            bus.rd_sex  = 2'($urandom);
            bus.rfp_op  = 2'($urandom);
            bus.rfp_din = 2'($urandom);
            cycle();
            check("rnd_data0", bus.rd_data[31:0],  exp_data[0]);
            check("rnd_data1", bus.rd_data[63:32], exp_data[1]);
            check("rnd_valid", 32'(bus.rd_valid),  32'(exp_valid));
            check("rnd_rfp",   32'(bus.rfp),       32'(rfp_m));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit reached");
    end
endmodule
